// File: rtl/uart_rx_parity_frame_checker.sv
`default_nettype none
// ============================================================================
// uart_rx_parity_frame_checker : serial parity/stop-bit checker with
// saturating error counters.  Rev 1.0
// ============================================================================
module uart_rx_parity_frame_checker #(
  parameter int WIDTH     = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       parity_mode,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             RX_data,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             frame_done,
  output logic             parity_bit_err,
  output logic             stop_bit_err,
  output logic             busy,
  output logic [CNT_W-1:0] parity_err_cnt,
  output logic [CNT_W-1:0] frame_err_cnt
);

  localparam int              BC_W      = $clog2(WIDTH + 1);
  localparam logic [BC_W-1:0] LAST_DATA = BC_W'(WIDTH - 1);
  localparam logic [1:0]      LAST_STOP = 2'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [2:0] MODE_EVEN  = 3'b001;
  localparam logic [2:0] MODE_ODD   = 3'b010;
  localparam logic [2:0] MODE_MARK  = 3'b011;
  localparam logic [2:0] MODE_SPACE = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic             run_par_q, run_par_d;
  logic             rx_par_q, rx_par_d;
  logic [1:0]       stop_cnt_q, stop_cnt_d;
  logic             stop_err_q, stop_err_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             frame_done_q, frame_done_d;
  logic             parity_flag_q, parity_flag_d;
  logic             stop_flag_q, stop_flag_d;
  logic [CNT_W-1:0] par_cnt_q, par_cnt_d;
  logic [CNT_W-1:0] frm_cnt_q, frm_cnt_d;

  logic mode_none;
  logic exp_par;
  logic stop_err_next;

  // Anything outside the four parity modes behaves as "no parity slot".
  always_comb begin
    mode_none = 1'b1;
    exp_par   = 1'b0;
    case (mode_q)
      MODE_EVEN:  begin mode_none = 1'b0; exp_par = run_par_q;  end
      MODE_ODD:   begin mode_none = 1'b0; exp_par = ~run_par_q; end
      MODE_MARK:  begin mode_none = 1'b0; exp_par = 1'b1;       end
      MODE_SPACE: begin mode_none = 1'b0; exp_par = 1'b0;       end
      default:    begin mode_none = 1'b1; exp_par = 1'b0;       end
    endcase
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    run_par_d      = run_par_q;
    rx_par_d       = rx_par_q;
    stop_cnt_d     = stop_cnt_q;
    stop_err_d     = stop_err_q;
    data_out_d     = data_out_q;
    frame_done_d   = 1'b0;
    parity_flag_d  = parity_flag_q;
    stop_flag_d    = stop_flag_q;
    stop_err_next  = stop_err_q | ~RX_data;

    // start restarts a frame from any state and swallows a coincident bit.
    if (start) begin
      state_d    = DATA;
      mode_d     = parity_mode;
      shift_d    = '0;
      bit_cnt_d  = '0;
      run_par_d  = 1'b0;
      rx_par_d   = 1'b0;
      stop_cnt_d = 2'd0;
      stop_err_d = 1'b0;
    end else if (bit_valid) begin
      case (state_q)
        DATA: begin
          shift_d   = {RX_data, shift_q[WIDTH-1:1]};
          run_par_d = run_par_q ^ RX_data;
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (bit_cnt_q == LAST_DATA) begin
            state_d = mode_none ? STOP : PARITY;
          end
        end
        PARITY: begin
          rx_par_d = RX_data;
          state_d  = STOP;
        end
        STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d       = IDLE;
            frame_done_d  = 1'b1;
            data_out_d    = shift_q;
            parity_flag_d = ~mode_none & (rx_par_q != exp_par);
            stop_flag_d   = stop_err_next;
          end else begin
            stop_cnt_d = stop_cnt_q + 2'd1;
            stop_err_d = stop_err_next;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Counters act on the registered flags, so they move one cycle after frame_done.
  always_comb begin
    par_cnt_d = par_cnt_q;
    frm_cnt_d = frm_cnt_q;
    if (cnt_clr) begin
      par_cnt_d = '0;
      frm_cnt_d = '0;
    end else if (frame_done_q) begin
      if (parity_flag_q && (par_cnt_q != CNT_MAX)) begin
        par_cnt_d = par_cnt_q + CNT_W'(1);
      end
      if (stop_flag_q && (frm_cnt_q != CNT_MAX)) begin
        frm_cnt_d = frm_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mode_q        <= 3'b000;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      run_par_q     <= 1'b0;
      rx_par_q      <= 1'b0;
      stop_cnt_q    <= 2'd0;
      stop_err_q    <= 1'b0;
      data_out_q    <= '0;
      frame_done_q  <= 1'b0;
      parity_flag_q <= 1'b0;
      stop_flag_q   <= 1'b0;
      par_cnt_q     <= '0;
      frm_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      run_par_q     <= run_par_d;
      rx_par_q      <= rx_par_d;
      stop_cnt_q    <= stop_cnt_d;
      stop_err_q    <= stop_err_d;
      data_out_q    <= data_out_d;
      frame_done_q  <= frame_done_d;
      parity_flag_q <= parity_flag_d;
      stop_flag_q   <= stop_flag_d;
      par_cnt_q     <= par_cnt_d;
      frm_cnt_q     <= frm_cnt_d;
    end
  end

  assign data_out       = data_out_q;
  assign frame_done     = frame_done_q;
  assign parity_bit_err = parity_flag_q;
  assign stop_bit_err   = stop_flag_q;
  assign busy           = (state_q != IDLE);
  assign parity_err_cnt = par_cnt_q;
  assign frame_err_cnt  = frm_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_parity_frame_checker.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_parity_frame_checker : two configurations driven by one stream,
// compared every cycle against a frame-level model.  Rev 1.0
// ============================================================================
module tb_uart_rx_parity_frame_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] parity_mode = 3'b000;
  logic       start = 1'b0, bit_valid = 1'b0, RX_data = 1'b1, cnt_clr = 1'b0;

  logic [7:0] a_data, b_data;
  logic       a_done, a_perr, a_serr, a_busy;
  logic       b_done, b_perr, b_serr, b_busy;
  logic [7:0] a_pcnt, a_fcnt;
  logic [1:0] b_pcnt, b_fcnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_rx_parity_frame_checker #(.WIDTH(8), .STOP_BITS(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .parity_mode(parity_mode), .start(start),
    .bit_valid(bit_valid), .RX_data(RX_data), .cnt_clr(cnt_clr),
    .data_out(a_data), .frame_done(a_done), .parity_bit_err(a_perr),
    .stop_bit_err(a_serr), .busy(a_busy), .parity_err_cnt(a_pcnt),
    .frame_err_cnt(a_fcnt));

  uart_rx_parity_frame_checker #(.WIDTH(8), .STOP_BITS(2), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .parity_mode(parity_mode), .start(start),
    .bit_valid(bit_valid), .RX_data(RX_data), .cnt_clr(cnt_clr),
    .data_out(b_data), .frame_done(b_done), .parity_bit_err(b_perr),
    .stop_bit_err(b_serr), .busy(b_busy), .parity_err_cnt(b_pcnt),
    .frame_err_cnt(b_fcnt));

  // Frame-level model: collect the bits since start, judge the frame once the
  // expected number of bits has arrived.
  typedef struct packed {
    logic        active;
    logic [2:0]  mode;
    logic [15:0] bits;
    logic [4:0]  n;
    logic [7:0]  data;
    logic        done;
    logic        perr;
    logic        serr;
    logic [7:0]  pcnt;
    logic [7:0]  fcnt;
  } mdl_t;

  mdl_t ma = '0, mb = '0;

  function automatic mdl_t step(input mdl_t m, input int w, input int sb, input int cw,
                                input logic r, input logic st, input logic bv,
                                input logic rx, input logic clr, input logic [2:0] pm);
    mdl_t o = m;
    int   maxc = (1 << cw) - 1;
    int   len;
    logic none, x, ex;
    if (r) return '0;
    if (clr) begin
      o.pcnt = 8'd0;
      o.fcnt = 8'd0;
    end else if (m.done) begin
      if (m.perr && (int'(m.pcnt) != maxc)) o.pcnt = m.pcnt + 8'd1;
      if (m.serr && (int'(m.fcnt) != maxc)) o.fcnt = m.fcnt + 8'd1;
    end
    o.done = 1'b0;
    if (st) begin
      o.active = 1'b1;
      o.mode   = pm;
      o.n      = 5'd0;
      o.bits   = '0;
    end else if (m.active && bv) begin
      o.bits[m.n] = rx;
      o.n = m.n + 5'd1;
      none = !(m.mode inside {3'd1, 3'd2, 3'd3, 3'd4});
      len = w + (none ? 0 : 1) + sb;
      if (int'(o.n) == len) begin
        o.active = 1'b0;
        o.done   = 1'b1;
        o.data   = '0;
        x = 1'b0;
        for (int i = 0; i < w; i++) begin
          o.data[i] = o.bits[i];
          x ^= o.bits[i];
        end
        case (m.mode)
          3'd1:    ex = x;
          3'd2:    ex = ~x;
          3'd3:    ex = 1'b1;
          default: ex = 1'b0;
        endcase
        o.perr = none ? 1'b0 : (o.bits[w] != ex);
        o.serr = 1'b0;
        for (int i = 0; i < sb; i++) if (!o.bits[len - sb + i]) o.serr = 1'b1;
      end
    end
    return o;
  endfunction

  always @(posedge clk) begin
    ma = step(ma, 8, 1, 8, rst, start, bit_valid, RX_data, cnt_clr, parity_mode);
    mb = step(mb, 8, 2, 2, rst, start, bit_valid, RX_data, cnt_clr, parity_mode);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("A.busy", 16'(a_busy), 16'(ma.active));
      chk("A.done", 16'(a_done), 16'(ma.done));
      chk("A.data", 16'(a_data), 16'(ma.data));
      chk("A.perr", 16'(a_perr), 16'(ma.perr));
      chk("A.serr", 16'(a_serr), 16'(ma.serr));
      chk("A.pcnt", 16'(a_pcnt), 16'(ma.pcnt));
      chk("A.fcnt", 16'(a_fcnt), 16'(ma.fcnt));
      chk("B.busy", 16'(b_busy), 16'(mb.active));
      chk("B.done", 16'(b_done), 16'(mb.done));
      chk("B.data", 16'(b_data), 16'(mb.data));
      chk("B.perr", 16'(b_perr), 16'(mb.perr));
      chk("B.serr", 16'(b_serr), 16'(mb.serr));
      chk("B.pcnt", 16'(b_pcnt), 16'(mb.pcnt));
      chk("B.fcnt", 16'(b_fcnt), 16'(mb.fcnt));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; bit_valid = 1'b0; cnt_clr = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic do_start(input logic [2:0] m);
    @(negedge clk);
    start = 1'b1; bit_valid = 1'b0; cnt_clr = 1'b0; parity_mode = m;
  endtask

  // Mode is scrambled on every bit to show it only matters at start.
  task automatic send_bit(input logic b);
    idle($urandom_range(0, 2));
    @(negedge clk);
    start = 1'b0; bit_valid = 1'b1; RX_data = b; cnt_clr = 1'b0;
    parity_mode = 3'($urandom);
  endtask

  task automatic frame(input logic [2:0] m, input logic [7:0] d, input logic p,
                       input logic has_p, input logic s0, input logic s1, input logic clr);
    do_start(m);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_p) send_bit(p);
    send_bit(s0);
    send_bit(s1);
    @(negedge clk);
    bit_valid = 1'b0; cnt_clr = clr;
    idle(3);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    idle(1);
    chk("reset A.busy", 16'(a_busy), 16'd0);
    chk("reset A.data", 16'(a_data), 16'd0);
    chk("reset B.pcnt", 16'(b_pcnt), 16'd0);

    frame(3'b001, 8'hCF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t1 A.data", 16'(a_data), 16'h00CF);
    chk("t1 A.perr", 16'(a_perr), 16'd0);
    chk("t1 A.serr", 16'(a_serr), 16'd0);

    frame(3'b001, 8'hCF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t2 A.perr", 16'(a_perr), 16'd1);
    chk("t2 A.pcnt", 16'(a_pcnt), 16'd1);
    frame(3'b010, 8'hCF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t2 odd A.perr", 16'(a_perr), 16'd0);

    frame(3'b011, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3 mark A.perr", 16'(a_perr), 16'd1);
    frame(3'b100, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3 space A.perr", 16'(a_perr), 16'd0);
    frame(3'b010, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3 odd A.perr", 16'(a_perr), 16'd0);
    chk("t3 odd A.serr", 16'(a_serr), 16'd1);
    chk("t3 odd A.fcnt", 16'(a_fcnt), 16'd1);

    frame(3'b000, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4 B.data", 16'(b_data), 16'h00A5);
    chk("t4 B.serr", 16'(b_serr), 16'd1);
    chk("t4 B.perr", 16'(b_perr), 16'd0);
    chk("t4 A.serr", 16'(a_serr), 16'd0);

    repeat (5) frame(3'b001, 8'hCF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5 B.pcnt sat", 16'(b_pcnt), 16'd3);
    chk("t5 A.pcnt", 16'(a_pcnt), 16'd7);
    frame(3'b001, 8'hCF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5 B.pcnt clr", 16'(b_pcnt), 16'd0);
    chk("t5 A.pcnt clr", 16'(a_pcnt), 16'd0);

    do_start(3'b001);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    bit_valid = 1'b0; rst = 1'b1;
    idle(1);
    chk("t6 rst A.busy", 16'(a_busy), 16'd0);
    chk("t6 rst A.data", 16'(a_data), 16'd0);
    chk("t6 rst A.perr", 16'(a_perr), 16'd0);
    do_start(3'b001);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    frame(3'b001, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t6 A.data", 16'(a_data), 16'h003C);
    chk("t6 B.data", 16'(b_data), 16'h003C);
    chk("t6 B.perr", 16'(b_perr), 16'd0);

    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 999) == 0);
      start       = ($urandom_range(0, 59) == 0);
      bit_valid   = 1'($urandom_range(0, 1));
      RX_data     = ($urandom_range(0, 9) < 7);
      cnt_clr     = ($urandom_range(0, 79) == 0);
      parity_mode = 3'($urandom);
    end
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
